bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
- Controller that sequences a 4-digit chain of mod-10 (BCD) counting stages as a start/stop/lap/clear stopwatch.
- Owns the run/pause state machine, a clock prescaler that generates the count tick, the digit-to-digit carry chain and a lap snapshot register for the display.
- Sits between debounced one-cycle button pulses and the 7-segment display driver.

Parameters:
- TICK_DIV, 10, clock cycles per count increment; legal range 2..2^TICK_W.
- TICK_W, 4, prescaler width in bits; must satisfy TICK_DIV <= 2^TICK_W.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start_stop  input  1  one-cycle pulse that toggles run/pause.
- lap  input  1  one-cycle pulse that freezes or releases the display while counting continues.
- clear  input  1  one-cycle pulse that zeroes the count; honoured only in IDLE or PAUSE.
- digits_out  output  16  BCD digits {d3,d2,d1,d0}; d0 is least significant.
- running  output  1  high in RUN or LAP.
- tick  output  1  high in the cycle the count advances.
- overflow  output  1  sticky flag, set on the 9999->0000 wrap.

Behaviour:
- Reset (rst=1 at a clk edge) sets state=IDLE, prescaler=0, all digits=0, snapshot=0, overflow=0, running=0, tick=0. Reset overrides every input and applies mid-count and in any state.
- Every cycle an input is high counts as one event. Upstream guarantees single-cycle pulses.
- FSM states are IDLE, RUN, PAUSE, LAP. State is registered and updates at the clk edge where the event is sampled.
- IDLE:
  - start_stop -> RUN.
  - clear -> stay IDLE and re-zero digits, prescaler and overflow.
  - lap is ignored.
- RUN:
  - start_stop -> PAUSE.
  - lap (without start_stop) -> LAP; the snapshot is loaded with the live digits at the same edge.
  - clear is ignored.
- LAP:
  - lap -> RUN; the display returns to live digits.
  - start_stop -> PAUSE; the display returns to live digits.
  - clear is ignored.
- PAUSE:
  - start_stop -> RUN.
  - clear -> IDLE, zeroing digits, prescaler and overflow.
  - lap is ignored.
- Priority for simultaneous events:
  - start_stop beats lap in RUN and LAP.
  - clear beats start_stop in PAUSE and IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP, wrapping to 0.
  - Holds its value in PAUSE, so a resumed run keeps the fractional tick.
  - Is cleared by rst and by an honoured clear.
- tick is combinational and equals (state in {RUN, LAP}) AND (prescaler == TICK_DIV-1).
- Digit update at the edge ending a tick cycle:
  - d0 increments modulo 10.
  - d(k) increments only when all lower digits are 9.
  - Each digit wraps 9->0 and never holds an illegal BCD code.
  - 9999 -> 0000 and overflow is set to 1.
  - overflow stays set until rst or an honoured clear.
- digits_out shows the snapshot while in LAP, otherwise the live digits. It is registered and glitch-free across state changes.
- running = (state == RUN) or (state == LAP).
- Latency:
  - start_stop sampled at edge N puts state in RUN after edge N.
  - With prescaler=0, the first tick is in cycle N+TICK_DIV and digits change at edge N+TICK_DIV.

Test Plan:
- TICK_DIV=4: reset, start_stop pulse, run 40 cycles -> tick every 4th cycle, digits_out=0x0010 after 10 ticks, running=1, overflow=0.
- Carry and wrap: run to 0x0099, one more tick -> 0x0100. Run to 0x9999, one more tick -> 0x0000 and overflow=1. overflow stays 1 through further ticks until clear in PAUSE.
- Lap: at digits 0x0025 pulse lap -> digits_out holds 0x0025 while the internal count keeps advancing. Pulse lap again at internal 0x0031 -> digits_out=0x0031 next cycle.
- Pause/resume: start_stop at prescaler=2 -> PAUSE, prescaler and digits frozen for 20 cycles. start_stop again -> first tick after 1 cycle (prescaler 2->3). clear in RUN ignored; clear in PAUSE -> 0x0000, IDLE, overflow=0.
- Simultaneous events: lap+start_stop in RUN -> PAUSE, no snapshot taken. clear+start_stop in PAUSE -> IDLE with zero count.
- rst asserted mid-RUN at 0x0473 and in LAP -> next cycle IDLE, digits_out=0x0000, running=0, tick=0, overflow=0.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch controller driving a 4-digit BCD count chain.
// Latency: state, count and display all update at the edge that samples a button pulse; tick is combinational.
// Backpressure: none; every high input cycle is one event, and clear is dropped while counting.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start_stop  one-cycle pulse, toggles run/pause
//   lap         one-cycle pulse, freezes/releases the display while counting continues
//   clear       one-cycle pulse, zeroes the count (only when idle or paused)
//   digits_out  registered display digits {d3,d2,d1,d0}, d0 least significant
//   running     high while counting (RUN or LAP)
//   tick        high in the cycle the count advances
//   overflow    sticky 9999->0000 wrap flag
module bcd_stopwatch_ctrl #(
    parameter int TICK_DIV = 10,
    parameter int TICK_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] digits_out,
    output logic        running,
    output logic        tick,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam logic [TICK_W-1:0] PRESC_MAX = TICK_W'(TICK_DIV - 1);

    state_t            state;
    state_t            state_nxt;
    logic [TICK_W-1:0] presc;
    logic [TICK_W-1:0] presc_nxt;
    logic [15:0]       digits;
    logic [15:0]       digits_inc;
    logic [15:0]       digits_nxt;
    logic [15:0]       snap;
    logic [15:0]       snap_nxt;
    logic [15:0]       disp_nxt;
    logic [4:0]        carry;
    logic              ovf_nxt;
    logic              zero_cnt;
    logic              snap_ld;

    // Next-state decode. Priority: start_stop over lap while counting,
    // clear over start_stop while stopped.
    always_comb begin
        state_nxt = state;
        zero_cnt  = 1'b0;
        snap_ld   = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    zero_cnt = 1'b1;
                end else if (start_stop) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (start_stop) begin
                    state_nxt = PAUSE;
                end else if (lap) begin
                    state_nxt = LAP;
                    snap_ld   = 1'b1;
                end
            end
            LAP: begin
                if (start_stop) begin
                    state_nxt = PAUSE;
                end else if (lap) begin
                    state_nxt = RUN;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_nxt = IDLE;
                    zero_cnt  = 1'b1;
                end else if (start_stop) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign running = (state == RUN) || (state == LAP);
    assign tick    = running && (presc == PRESC_MAX);

    // Ripple carry across the digits: a digit steps only when every lower
    // digit is 9 and a tick is present, wrapping 9->0.
    always_comb begin
        digits_inc = digits;
        carry      = '0;
        carry[0]   = tick;
        for (int k = 0; k < 4; k++) begin
            if (carry[k]) begin
                digits_inc[4*k +: 4] = (digits[4*k +: 4] == 4'd9) ? 4'd0 : digits[4*k +: 4] + 4'd1;
            end
            carry[k+1] = carry[k] && (digits[4*k +: 4] == 4'd9);
        end
    end

    always_comb begin
        presc_nxt  = presc;
        digits_nxt = digits_inc;
        ovf_nxt    = overflow | carry[4];
        if (zero_cnt) begin
            presc_nxt  = '0;
            digits_nxt = '0;
            ovf_nxt    = 1'b0;
        end else if (running) begin
            // Prescaler holds while paused so a resume keeps the partial tick.
            presc_nxt = (presc == PRESC_MAX) ? '0 : presc + TICK_W'(1);
        end
        snap_nxt = snap_ld ? digits : snap;
        // Display is computed from next-state values and registered, so it
        // switches cleanly on the same edge as the state change.
        disp_nxt = (state_nxt == LAP) ? snap_nxt : digits_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            digits     <= '0;
            snap       <= '0;
            overflow   <= 1'b0;
            digits_out <= '0;
        end else begin
            state      <= state_nxt;
            presc      <= presc_nxt;
            digits     <= digits_nxt;
            snap       <= snap_nxt;
            overflow   <= ovf_nxt;
            digits_out <= disp_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Directed bench for bcd_stopwatch_ctrl with TICK_DIV=4 and a 2-bit prescaler.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Expected values are hand-computed constants or a plain BCD conversion of a tick count.
module tb_bcd_stopwatch_ctrl;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits_out;
    logic        running;
    logic        tick;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(
        .TICK_DIV(TICK_DIV),
        .TICK_W  (TICK_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_stop(start_stop),
        .lap       (lap),
        .clear     (clear),
        .digits_out(digits_out),
        .running   (running),
        .tick      (tick),
        .overflow  (overflow)
    );

    typedef struct {
        logic        r;
        logic        ss;
        logic        lp;
        logic        cl;
        logic [15:0] d;
        logic        run;
        logic        tk;
        logic        ov;
    } vec_t;

    vec_t vecs[26];

    task automatic step(input logic r, input logic ss, input logic lp, input logic cl);
        rst = r; start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        #1;
        rst = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] d, input logic run,
                           input logic tk, input logic ov);
        chk16({name, ".digits"}, digits_out, d);
        chk1({name, ".running"}, running, run);
        chk1({name, ".tick"}, tick, tk);
        chk1({name, ".overflow"}, overflow, ov);
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    initial begin
        //               rst   ss    lap   clr   digits    run   tick  ovf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}; // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}; // idle
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0}; // lap ignored in IDLE
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}; // clear in IDLE
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}; // clear beats ss in IDLE
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}; // RUN, presc 0
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}; // presc 1
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0}; // clear ignored, presc 2
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0}; // presc 3 -> tick
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0}; // first increment
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0}; // presc 1
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0}; // ss beats lap -> PAUSE, presc 2
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0}; // paused
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0}; // lap ignored in PAUSE
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0}; // resume, presc 2
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0}; // presc 3 -> tick
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0}; // presc 0
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0}; // LAP, snap=0002, presc 1
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0}; // presc 2
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0}; // presc 3 -> tick
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0}; // live 0003, shows snapshot
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0}; // back to RUN, live
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b0}; // LAP again, presc 2
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0}; // ss in LAP -> PAUSE, presc 3
        vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0}; // clear beats ss -> IDLE
        vecs[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}; // RUN, presc restarted at 0

        for (int i = 0; i < 26; i++) begin
            step(vecs[i].r, vecs[i].ss, vecs[i].lp, vecs[i].cl);
            chk_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].run, vecs[i].tk, vecs[i].ov);
        end

        // 40 cycles of counting: tick every 4th cycle, 0x0010 at the end.
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk1($sformatf("run40.tick%0d", i), tick, (i % 4) == 3);
            chk16($sformatf("run40.digits%0d", i), digits_out, to_bcd(i / 4));
        end
        chk_all("run40.end", 16'h0010, 1'b1, 1'b0, 1'b0);

        // Lap freeze at 0x0025 while the live count reaches 0x0031.
        run_idle(60);
        chk16("lap.pre", digits_out, 16'h0025);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk16("lap.take", digits_out, 16'h0025);
        chk1("lap.running", running, 1'b1);
        for (int i = 1; i <= 23; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk16($sformatf("lap.hold%0d", i), digits_out, 16'h0025);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk16("lap.release", digits_out, 16'h0031);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk16("lap.live", digits_out, 16'h0031);

        // Carry 0x0099 -> 0x0100.
        run_idle(2);
        chk16("carry.0032", digits_out, 16'h0032);
        run_idle(268);
        chk16("carry.0099", digits_out, 16'h0099);
        run_idle(3);
        chk_all("carry.tick", 16'h0099, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("carry.0100", 16'h0100, 1'b1, 1'b0, 1'b0);

        // Pause with the prescaler left at 2, frozen for 20 cycles, resume.
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("pause.enter", 16'h0100, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            chk16($sformatf("pause.digits%0d", i), digits_out, 16'h0100);
            chk1($sformatf("pause.tick%0d", i), tick, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("resume.enter", 16'h0100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("resume.tick", 16'h0100, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("resume.0101", 16'h0101, 1'b1, 1'b0, 1'b0);

        // Wrap 9999 -> 0000 with sticky overflow, then clear in PAUSE.
        run_idle(39592);
        chk_all("wrap.9999", 16'h9999, 1'b1, 1'b0, 1'b0);
        run_idle(3);
        chk_all("wrap.tick", 16'h9999, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("wrap.0000", 16'h0000, 1'b1, 1'b0, 1'b1);
        run_idle(8);
        chk_all("wrap.sticky", 16'h0002, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("wrap.pause", 16'h0002, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("wrap.clear", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("clr.restart", 16'h0000, 1'b1, 1'b0, 1'b0);
        run_idle(3);
        chk1("clr.presc_zeroed", tick, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk16("clr.0001", digits_out, 16'h0001);

        // Reset mid-RUN at 0x0473.
        run_idle(1888);
        chk_all("rstrun.0473", 16'h0473, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("rstrun.after", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("rstrun.idle", 16'h0000, 1'b0, 1'b0, 1'b0);

        // Reset while in LAP.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        run_idle(8);
        chk16("rstlap.0002", digits_out, 16'h0002);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        run_idle(4);
        chk16("rstlap.frozen", digits_out, 16'h0002);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("rstlap.after", 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("rstlap.idle", 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
